// File: rtl/ifetch_pipe.sv
// Instruction fetch unit: owns the PC, fetches over the shared bus, and feeds ir0q/ir1q to the decoder.
// Optional bubble counter output enabled by defining IFETCH_PERF_EN.
module ifetch_pipe #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0000,
    parameter logic [15:0] HALT_OP  = 16'hFFFF,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] pc,
    input  logic [15:0] jump_target,
    input  logic        dojump,
    input  logic        clrIr0,
    input  logic        sel_addr_reg,
    output logic [15:0] ir0q,
    output logic [15:0] ir1q,
`ifdef IFETCH_PERF_EN
    output logic [15:0] bubble_cnt,
`endif
    output logic        halted,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state, state_d;
    logic [15:0] pc_d, ir0_d, ir1_d;
    logic [7:0]  wcnt, wcnt_d;
    logic        berr_d;
`ifdef IFETCH_PERF_EN
    logic        bubble;
`endif

    function automatic logic [7:0] wcnt_inc(input logic [7:0] c);
        if (c >= TMO) return TMO;
        return c + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        if (c == 16'hFFFF) return c;
        return c + 16'd1;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        state   <= state_d;
        pc      <= pc_d;
        ir0q    <= ir0_d;
        ir1q    <= ir1_d;
        wcnt    <= wcnt_d;
        bus_err <= berr_d;
    end

    // Next-state logic; branch order is the rule priority
    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir0_d   = ir0q;
        ir1_d   = ir1q;
        wcnt_d  = wcnt;
        berr_d  = bus_err;
`ifdef IFETCH_PERF_EN
        bubble  = 1'b0;
`endif
        if (reset) begin
            state_d = S_RUN;
            pc_d    = RESET_PC;
            ir0_d   = NOP;
            ir1_d   = NOP;
            wcnt_d  = 8'd0;
            berr_d  = 1'b0;
        end else if (state == S_HALT) begin
            ir1_d = NOP;
        end else begin
            ir1_d = ir0q;
            ir0_d = NOP;
`ifdef IFETCH_PERF_EN
            bubble = 1'b1;
`endif
            if (dojump) begin
                pc_d    = jump_target;
                state_d = S_RUN;
                wcnt_d  = 8'd0;
            end else if (sel_addr_reg) begin
                // data cycle: pc, state and wait count untouched
            end else if (!mem_ack) begin
                state_d = S_WAIT;
                wcnt_d  = wcnt_inc(wcnt);
                if (wcnt_d == TMO) begin
                    berr_d  = 1'b1;
                    state_d = S_HALT;
                end
            end else if (clrIr0) begin
                pc_d    = pc + 16'd1;
                state_d = S_RUN;
                wcnt_d  = 8'd0;
            end else begin
                ir0_d   = mem_data;
                pc_d    = pc + 16'd1;
                state_d = S_RUN;
                wcnt_d  = 8'd0;
`ifdef IFETCH_PERF_EN
                bubble  = 1'b0;
`endif
            end
            if (ir0q == HALT_OP) state_d = S_HALT;
        end
    end

    // Outputs
    always_comb begin
        halted   = (state == S_HALT);
        mem_req  = ~reset & (state != S_HALT) & ~sel_addr_reg & ~dojump;
        mem_addr = pc;
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)       bubble_cnt <= 16'd0;
        else if (bubble) bubble_cnt <= sat_inc16(bubble_cnt);
    end
`endif

endmodule

// File: tb/tb_ifetch_pipe.sv
// Directed self-checking bench for ifetch_pipe; perf counter checks compile in with IFETCH_PERF_EN.
module tb_ifetch_pipe;

    logic        clk;
    logic        reset;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] pc;
    logic [15:0] jump_target;
    logic        dojump;
    logic        clrIr0;
    logic        sel_addr_reg;
    logic [15:0] ir0q;
    logic [15:0] ir1q;
    logic        halted;
    logic        bus_err;
`ifdef IFETCH_PERF_EN
    logic [15:0] bubble_cnt;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    ifetch_pipe dut (
        .clk(clk), .reset(reset), .mem_data(mem_data), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_addr(mem_addr), .pc(pc),
        .jump_target(jump_target), .dojump(dojump), .clrIr0(clrIr0),
        .sel_addr_reg(sel_addr_reg), .ir0q(ir0q), .ir1q(ir1q),
`ifdef IFETCH_PERF_EN
        .bubble_cnt(bubble_cnt),
`endif
        .halted(halted), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dojump = 0; clrIr0 = 0; sel_addr_reg = 0; jump_target = 16'h0;
    endtask

    initial begin
        reset = 1; mem_data = 16'h0; mem_ack = 0;
        idle();
        #1;
        chk("req_in_reset", 16'(mem_req), 16'd0);
        step(); step();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir0", ir0q, 16'h0000);
        chk("rst_ir1", ir1q, 16'h0000);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_berr", 16'(bus_err), 16'd0);
        reset = 0;

        // straight-line fetch
        mem_ack = 1; mem_data = 16'h1234;
        #1;
        chk("req_run", 16'(mem_req), 16'd1);
        chk("addr0", mem_addr, 16'h0000);
        step();
        chk("sl_pc1", pc, 16'h0001);
        chk("sl_ir0_1", ir0q, 16'h1234);
        mem_data = 16'h5678;
        step();
        chk("sl_pc2", pc, 16'h0002);
        chk("sl_ir0_2", ir0q, 16'h5678);
        chk("sl_ir1_2", ir1q, 16'h1234);
        mem_data = 16'h0011; step();
        mem_data = 16'h0022; step();
        mem_data = 16'h0033; step();
        chk("pc5", pc, 16'h0005);

        // jump with one bubble
        dojump = 1; jump_target = 16'h0040; mem_data = 16'h0044;
        #1;
        chk("req_jump", 16'(mem_req), 16'd0);
        step();
        chk("jmp_pc", pc, 16'h0040);
        chk("jmp_ir0", ir0q, 16'h0000);
        chk("jmp_ir1", ir1q, 16'h0033);
        idle(); mem_data = 16'h0055;
        #1;
        chk("jmp_addr", mem_addr, 16'h0040);
        chk("jmp_req", 16'(mem_req), 16'd1);
        step();
        chk("tgt_ir0", ir0q, 16'h0055);
        chk("tgt_pc", pc, 16'h0041);

        // immediate consumption at pc=7
        dojump = 1; jump_target = 16'h0007; step(); idle();
        clrIr0 = 1; mem_data = 16'h0ABC;
        step();
        chk("imm_pc", pc, 16'h0008);
        chk("imm_ir0", ir0q, 16'h0000);
        idle(); mem_data = 16'h0101; step();
        chk("pc9", pc, 16'h0009);

        // data cycle
        sel_addr_reg = 1;
        #1;
        chk("sel_req", 16'(mem_req), 16'd0);
        step();
        chk("sel_pc", pc, 16'h0009);
        chk("sel_ir0", ir0q, 16'h0000);
        chk("sel_ir1", ir1q, 16'h0101);
        idle();

        // three wait states then ack
        mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_pc", pc, 16'h0009);
            chk("wait_ir0", ir0q, 16'h0000);
        end
        chk("wait_berr", 16'(bus_err), 16'd0);
        mem_ack = 1; mem_data = 16'h0303; step();
        chk("wack_pc", pc, 16'h000A);
        chk("wack_ir0", ir0q, 16'h0303);

        // timeout after 15 unacked cycles
        mem_ack = 0;
        for (int i = 0; i < 14; i++) step();
        chk("tmo14_halted", 16'(halted), 16'd0);
        chk("tmo14_berr", 16'(bus_err), 16'd0);
        step();
        chk("tmo_berr", 16'(bus_err), 16'd1);
        chk("tmo_halted", 16'(halted), 16'd1);
        mem_ack = 1;
        #1;
        chk("tmo_req", 16'(mem_req), 16'd0);
        step();
        chk("tmo_pc", pc, 16'h000A);
        chk("tmo_berr_hold", 16'(bus_err), 16'd1);
        reset = 1; step(); reset = 0;
        chk("clr_berr", 16'(bus_err), 16'd0);
        chk("clr_halted", 16'(halted), 16'd0);
        chk("clr_pc", pc, 16'h0000);

        // pc wraparound
        dojump = 1; jump_target = 16'hFFFF; step(); idle();
        chk("wrap_pre", pc, 16'hFFFF);
        mem_data = 16'h0777; step();
        chk("wrap_pc", pc, 16'h0000);
        reset = 1; step(); reset = 0;

        // halt opcode
        mem_ack = 1; mem_data = 16'hFFFF; step();
        chk("h_ir0", ir0q, 16'hFFFF);
        chk("h_notyet", 16'(halted), 16'd0);
        mem_data = 16'h0001; step();
        chk("h_ir1", ir1q, 16'hFFFF);
        chk("h_halted", 16'(halted), 16'd1);
        chk("h_pc", pc, 16'h0002);
        step();
        chk("h_ir1_nop", ir1q, 16'h0000);
        chk("h_pc_frozen", pc, 16'h0002);
        chk("h_ir0_hold", ir0q, 16'h0001);
        chk("h_req", 16'(mem_req), 16'd0);

`ifdef IFETCH_PERF_EN
        reset = 1; step(); reset = 0;
        chk("perf_rst", bubble_cnt, 16'd0);
        mem_ack = 1; mem_data = 16'h0202; step();
        chk("perf_fetch", bubble_cnt, 16'd0);
        dojump = 1; jump_target = 16'h0020; step(); idle();
        mem_ack = 0; step(); step();
        chk("perf_cnt", bubble_cnt, 16'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
